stream_rr_arbiter: RTL and testbench

- Shares one valid/ready output stream between NUM_REQ requester streams using round-robin arbitration at burst granularity.
- A grant is held until the requester's last beat or until MAX_BURST beats, whichever comes first.
- The output is decoupled through a 2-entry skid_buffer instance, so all in_ready signals are registered-path only.
- Sits in front of the accelerator's shared input channel, for example when weight and activation fetchers contend for one bus.

---
 rtl/stream_arb_pkg.sv | 22 ++
 rtl/skid_buffer.sv | 70 +++++++
 rtl/stream_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and default constants for the stream round-robin arbiter.
//   arb_state_e : arbiter FSM state (idle / burst locked)
//   beat_t      : one output beat {data, last, id} laid out for the default configuration
package stream_arb_pkg;

    localparam int unsigned DEFAULT_NUM_REQ   = 4;
    localparam int unsigned DEFAULT_DATA_W    = 32;
    localparam int unsigned DEFAULT_MAX_BURST = 16;
    localparam int unsigned DEFAULT_ID_W      = $clog2(DEFAULT_NUM_REQ);

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      last;
        logic [DEFAULT_ID_W-1:0]   id;
    } beat_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer. Entry 0 drives the output; entry 1 catches the one beat
// that arrives in the cycle the downstream stalls. ready_out is taken straight from a flop so
// upstream never sees a combinational path from ready_in.
//   clk, rstn            : clock, asynchronous active-low reset
//   valid_in, data_in    : upstream beat
//   ready_out            : upstream ready (high while the skid entry is empty)
//   valid_out, data_out  : downstream beat, held stable while stalled
//   ready_in             : downstream ready
module skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_in
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;

    assign ready_out = ~skid_valid_q;
    assign in_fire   = valid_in & ready_out;
    assign valid_out = out_valid_q;
    assign data_out  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || ready_in) begin
            // Output entry frees up this cycle: the skid drains before any new beat.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = data_in;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output stream between NUM_REQ requesters.
// A grant covers a whole burst: it is held until the requester's last beat or MAX_BURST beats.
// The output goes through a skid_buffer so every in_ready bit is a pure flop-derived signal.
//   clk, rstn              : clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready : NUM_REQ requester streams (data packed DATA_W each)
//   out_valid/out_data/out_last/out_id/out_ready : shared output stream with source index
//   busy                   : high while a burst is locked
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ-1:0]        in_last,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int unsigned      CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned      BEAT_W   = DATA_W + 1 + ID_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              skid_ready;
    logic              skid_valid;
    logic [BEAT_W-1:0] skid_out;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              locked;
    logic              accept;
    logic              terminal;
    logic [ID_W-1:0]   next_ptr;

    // First set bit at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign locked   = (state_q == StLocked);
    assign busy     = locked;
    assign accept   = locked & sel_valid & skid_ready;
    assign terminal = sel_last | (beat_cnt_q == LAST_CNT);
    assign next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        in_ready  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_valid   = in_valid[i];
                sel_last    = in_last[i];
                sel_data    = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = locked & skid_ready;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                // in_ready stays low here: one bubble per burst buys a registered grant.
                if (|in_valid) begin
                    grant_d    = rr_pick(in_valid, rr_ptr_q);
                    state_d    = StLocked;
                    beat_cnt_d = '0;
                end
            end
            StLocked: begin
                if (accept) begin
                    if (terminal) begin
                        state_d    = StIdle;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Forced-release beats carry last=1 so downstream sees a closed burst.
    skid_buffer #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (locked & sel_valid),
        .data_in  ({grant_q, terminal, sel_data}),
        .ready_out(skid_ready),
        .valid_out(skid_valid),
        .data_out (skid_out),
        .ready_in (out_ready)
    );

    assign out_valid = skid_valid;
    assign out_data  = skid_out[DATA_W-1:0];
    assign out_last  = skid_out[DATA_W];
    assign out_id    = skid_out[DATA_W+1 +: ID_W];

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;
    import stream_arb_pkg::*;

    localparam int unsigned NR = DEFAULT_NUM_REQ;
    localparam int unsigned DW = DEFAULT_DATA_W;
    localparam int unsigned MB = DEFAULT_MAX_BURST;
    localparam int unsigned IW = DEFAULT_ID_W;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    in_valid;
    logic [NR*DW-1:0] in_data;
    logic [NR-1:0]    in_last;
    logic [NR-1:0]    in_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic [IW-1:0]    out_id;
    logic             out_ready;
    logic             busy;

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .MAX_BURST(MB),
        .ID_W     (IW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_id   (out_id),
        .out_ready(out_ready),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] src_data [NR][24];
    logic          src_last [NR][24];
    int            src_len  [NR];
    int            src_idx  [NR];
    logic          src_en   [NR];

    beat_t log_beat [64];
    int    log_cyc  [64];
    int    log_n = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            in_valid[i]         = src_en[i] && (src_idx[i] < src_len[i]);
            in_data[i*DW +: DW] = in_valid[i] ? src_data[i][src_idx[i]] : '0;
            in_last[i]          = in_valid[i] && src_last[i][src_idx[i]];
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_idx[i] = 0;
            src_en[i]  = 1'b1;
        end
        log_n = 0;
        cyc   = 0;
        drive();
    endtask

    // last_every=0 means no in_last at all.
    task automatic load(input int req, input int n, input int base, input int last_every);
        for (int k = 0; k < n; k++) begin
            src_data[req][k] = DW'(base + k);
            src_last[req][k] = (last_every != 0) && (((k + 1) % last_every) == 0);
        end
        src_len[req] = n;
        src_idx[req] = 0;
    endtask

    // Sample handshakes for this slot, advance one edge, then update sources.
    task automatic cycle();
        logic [NR-1:0] fire;
        fire = in_valid & in_ready;
        chk("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
        if (out_valid && out_ready && log_n < 64) begin
            log_beat[log_n] = '{data: out_data, last: out_last, id: out_id};
            log_cyc[log_n]  = cyc;
            log_n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (fire[i]) src_idx[i]++;
        end
        drive();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        out_ready = 1'b1;
        clear_src();
        repeat (2) @(posedge clk);
        #1;
        rstn  = 1'b1;
        cyc   = 0;
        log_n = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_id  [8];
        int exp_cyc [8];
        int exp_dat [8];

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);

        // Single requester: req 2, three beats
        load(2, 3, 'hA0, 3);
        drive();
        chk("single_idle_in_ready", in_ready, 0);
        cycle();
        chk("single_busy", busy, 1);
        chk("single_in_ready", in_ready, 4'b0100);
        repeat (5) cycle();
        chk("single_count", log_n, 3);
        for (int k = 0; k < 3; k++) begin
            chk("single_data", log_beat[k].data, 'hA0 + k);
            chk("single_id", log_beat[k].id, 2);
            chk("single_last", log_beat[k].last, (k == 2) ? 1 : 0);
            chk("single_cyc", log_cyc[k], 2 + k);
        end
        chk("single_busy_after", busy, 0);
        // rr_ptr is now 3: req 3 wins over req 0, then wraps back to 0.
        log_n = 0;
        load(0, 1, 'h10, 1);
        load(3, 1, 'h30, 1);
        drive();
        repeat (8) cycle();
        chk("rr_count", log_n, 2);
        chk("rr_first_id", log_beat[0].id, 3);
        chk("rr_wrap_id", log_beat[1].id, 0);

        // Contention: reqs 0 and 1, bursts of two
        do_reset();
        load(0, 4, 'h100, 2);
        load(1, 4, 'h200, 2);
        drive();
        repeat (14) cycle();
        exp_id  = '{0, 0, 1, 1, 0, 0, 1, 1};
        exp_cyc = '{2, 3, 5, 6, 8, 9, 11, 12};
        exp_dat = '{'h100, 'h101, 'h200, 'h201, 'h102, 'h103, 'h202, 'h203};
        chk("cont_count", log_n, 8);
        for (int k = 0; k < 8; k++) begin
            chk("cont_id", log_beat[k].id, exp_id[k]);
            chk("cont_cyc", log_cyc[k], exp_cyc[k]);
            chk("cont_data", log_beat[k].data, exp_dat[k]);
            chk("cont_last", log_beat[k].last, k % 2);
        end

        // MAX_BURST forcing: 20 beats, no in_last
        do_reset();
        load(3, 20, 'h300, 0);
        drive();
        repeat (26) cycle();
        chk("maxb_count", log_n, 20);
        for (int k = 0; k < 20; k++) begin
            chk("maxb_data", log_beat[k].data, 'h300 + k);
            chk("maxb_id", log_beat[k].id, 3);
            chk("maxb_last", log_beat[k].last, (k == MB - 1) ? 1 : 0);
            chk("maxb_cyc", log_cyc[k], (k < MB) ? 2 + k : 3 + k);
        end
        chk("maxb_held_busy", busy, 1);

        // Back-pressure: out_ready low for slots 4..8
        do_reset();
        load(1, 8, 'hB0, 8);
        drive();
        for (int s = 0; s < 20; s++) begin
            if (s == 4) out_ready = 1'b0;
            if (s == 9) out_ready = 1'b1;
            if (s == 4) chk("bp_in_ready_before", in_ready, 4'b0010);
            if (s == 5 || s == 9) chk("bp_in_ready_low", in_ready, 0);
            if (s == 5 || s == 8) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_data, 'hB2);
                chk("bp_hold_id", out_id, 1);
            end
            if (s == 10) begin
                chk("bp_in_ready_back", in_ready, 4'b0010);
                chk("bp_skid_drain", out_data, 'hB3);
            end
            cycle();
        end
        exp_cyc = '{2, 3, 9, 10, 11, 12, 13, 14};
        chk("bp_count", log_n, 8);
        for (int k = 0; k < 8; k++) begin
            chk("bp_data", log_beat[k].data, 'hB0 + k);
            chk("bp_last", log_beat[k].last, (k == 7) ? 1 : 0);
            chk("bp_cyc", log_cyc[k], exp_cyc[k]);
        end

        // Valid drop: req 0 locked, drops valid for slots 3..5, req 1 waiting
        do_reset();
        load(0, 4, 'hC0, 4);
        load(1, 2, 'hD0, 2);
        drive();
        for (int s = 0; s < 16; s++) begin
            if (s == 3) begin
                src_en[0] = 1'b0;
                drive();
            end
            if (s == 6) begin
                src_en[0] = 1'b1;
                drive();
            end
            if (s == 4) begin
                chk("drop_busy", busy, 1);
                chk("drop_in_ready", in_ready, 4'b0001);
                chk("drop_out_valid", out_valid, 0);
            end
            if (s == 5) chk("drop_out_id", out_id, 0);
            cycle();
        end
        exp_id  = '{0, 0, 0, 0, 1, 1, 0, 0};
        exp_cyc = '{2, 3, 7, 8, 10, 11, 0, 0};
        exp_dat = '{'hC0, 'hC1, 'hC2, 'hC3, 'hD0, 'hD1, 0, 0};
        chk("drop_count", log_n, 6);
        for (int k = 0; k < 6; k++) begin
            chk("drop_id", log_beat[k].id, exp_id[k]);
            chk("drop_cyc", log_cyc[k], exp_cyc[k]);
            chk("drop_data", log_beat[k].data, exp_dat[k]);
        end

        // Reset mid-burst with both skid entries full
        do_reset();
        out_ready = 1'b0;
        load(2, 10, 'hE0, 0);
        drive();
        repeat (4) cycle();
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_in_ready", in_ready, 0);
        chk("mid_pre_data", out_data, 'hE0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", out_data, 0);
        clear_src();
        load(1, 1, 'hF1, 1);
        load(3, 1, 'hF3, 1);
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        cyc       = 0;
        log_n     = 0;
        repeat (8) cycle();
        chk("mid_after_count", log_n, 2);
        chk("mid_after_id0", log_beat[0].id, 1);
        chk("mid_after_data0", log_beat[0].data, 'hF1);
        chk("mid_after_id1", log_beat[1].id, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
